frame_tx: RTL and testbench
===========================

Name: frame_tx

Overview:
- Store-and-forward byte-stream frame transmitter that generates the stimulus side of the clk-synchronous rxd/rx_dv data channel.
- Accepts payload bytes on a valid/ready stream with a last flag and buffers whole frames in an internal FIFO.
- Emits each complete frame as preamble, SFD, payload and a 1-byte XOR FCS on txd/tx_en, followed by an enforced inter-frame gap.

Parameters:
- PRE_LEN, 7: number of 0x55 preamble bytes per frame, ≥1.
- IFG_LEN, 12: minimum idle cycles (tx_en=0) after each FCS byte, ≥1.
- MAX_LEN, 64: maximum payload bytes per frame; longer frames are truncated.
- FIFO_DEPTH, 64: payload FIFO entries (9 bits each: byte plus last flag); power of 2, ≥MAX_LEN.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset: rst_n, synchronous, active-low; clock clk.
- s_data  input  8  payload byte.
- s_valid  input  1  s_data/s_last valid.
- s_last  input  1  final payload byte of the frame.
- s_ready  output  1  block can accept a byte this cycle.
- txd  output  8  transmit byte; drives the channel's rxd.
- tx_en  output  1  txd valid; drives the channel's rx_dv.
- tx_frame_done  output  1  1-cycle pulse in the FCS cycle.
- trunc_err  output  1  1-cycle pulse when a frame is truncated.

Behaviour:
- Reset (rst_n=0 at an edge): txd=0, tx_en=0, tx_frame_done=0, trunc_err=0, s_ready=1. FIFO, pointers, frame count and FCS accumulator are cleared; FSM goes to IDLE.
- Reset mid-frame: tx_en drops after the next edge and any partial or buffered frames are lost.
- All outputs except s_ready are registered. s_ready = !(FIFO full), combinational from the FIFO count.
- Input accept: a byte is accepted when s_valid && s_ready at an edge.
- Write path:
  - An accepted byte is written with its last flag.
  - A byte count tracks the current incoming frame.
  - When the accepted byte is number MAX_LEN and s_last=0, it is written with last=1 and trunc_err pulses.
  - The following accepted bytes up to and including s_last=1 are discarded (not written); s_ready follows FIFO state during discard.
- Frame count:
  - Increments when a last-flagged entry is written.
  - Decrements when a last-flagged entry is popped.
  - A simultaneous increment and decrement leaves it unchanged.
  - A simultaneous FIFO write and pop is allowed.
- FSM states:
  - IDLE: tx_en=0, txd=0. If frame count>0 at an edge, go to PRE; txd=0x55 and tx_en=1 from that same edge. If the last byte is accepted at edge k with the FSM idle, tx_en is high after edge k+1.
  - PRE: output 0x55 for PRE_LEN cycles total, then SFD.
  - SFD: output 0xD5 for 1 cycle, clear the FCS accumulator, go to DATA.
  - DATA: pop 1 entry per cycle and output its byte; FCS ^= byte. A popped entry with last=1 moves the FSM to FCS.
  - FCS: output the accumulated XOR for 1 cycle; tx_frame_done=1; go to IFG.
  - IFG: tx_en=0, txd=0 for IFG_LEN cycles. Then go to PRE directly if frame count>0, else IDLE. Back-to-back frames are separated by exactly IFG_LEN idle cycles.
- tx_en high duration per frame is PRE_LEN+1+N+1 cycles (N = stored payload length, 1..MAX_LEN); tx_en is never deasserted inside a frame.
- Transmission starts only for complete frames, so upstream stalls never cause an underrun.
- No deadlock: FIFO full implies either complete frames are buffered or truncation has forced a last flag.
- txd=0 whenever tx_en=0.

Test Plan:
1. Frame 0x11,0x22,0x33,0x44 → 7×0x55, 0xD5, 11 22 33 44, FCS 0x44. tx_en high 13 cycles, tx_frame_done in cycle 13, then 12 idle cycles.
2. Two 1-byte frames 0xA5 then 0x3C, pushed back-to-back → second preamble starts exactly 12 cycles after the first FCS. FCS bytes are 0xA5 and 0x3C.
3. 70-byte frame with bytes 0..69 → trunc_err on byte 63 (0-based index). Bytes 64..69 are discarded. 64 payload bytes are sent with FCS = XOR(0..63) = 0x00.
4. Continuous 64-byte frames with s_valid held high → s_ready drops when the FIFO holds 64 entries. No byte is lost or reordered; each FCS is correct.
5. s_valid low for 20 cycles mid-frame (after 3 bytes) → tx_en stays 0 until s_last is accepted. The frame is then sent intact.
6. rst_n=0 for 1 cycle during DATA of a 10-byte frame → tx_en=0 and txd=0 next cycle, s_ready=1. A subsequent frame 0x5A is sent cleanly with FCS 0x5A.

Source files
------------

// File: rtl/frame_tx.sv
// frame_tx: store-and-forward byte-stream frame transmitter.
// Payload bytes arrive on a valid/ready stream with a last flag. They are
// buffered per frame in a FIFO. Each complete frame is sent on txd/tx_en as
// preamble, SFD, payload and a 1-byte XOR FCS. An inter-frame gap follows.
module frame_tx #(
    parameter int PRE_LEN    = 7,   // number of 0x55 preamble bytes, >= 1
    parameter int IFG_LEN    = 12,  // idle cycles after each FCS byte, >= 1
    parameter int MAX_LEN    = 64,  // payload bytes kept per frame; the rest is dropped
    parameter int FIFO_DEPTH = 64   // power of 2, >= MAX_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_frame_done,
    output logic       trunc_err
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int LW     = $clog2(MAX_LEN + 1);
    localparam int TMAX   = (PRE_LEN > IFG_LEN) ? PRE_LEN : IFG_LEN;
    localparam int TCW    = $clog2(TMAX + 1);

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_FCS,
        ST_IFG
    } state_t;

    // ------------------------------------------------------------------
    // Storage and bookkeeping registers
    // ------------------------------------------------------------------
    logic [8:0]     r_mem [FIFO_DEPTH];  // {last, byte}
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_fifo_cnt;
    logic [CW-1:0]  r_frame_cnt;         // complete frames held in the FIFO

    logic [LW-1:0]  r_byte_cnt;          // bytes written so far for the incoming frame
    logic           r_discard;           // dropping the tail of a truncated frame
    logic           r_trunc_err;

    state_t         r_state;
    logic [TCW-1:0] r_tcnt;              // preamble / gap cycle counter
    logic [7:0]     r_fcs;               // XOR of payload bytes sent so far
    logic           r_cur_last;          // byte on txd now is the frame's last
    logic [7:0]     r_txd;
    logic           r_tx_en;
    logic           r_tx_frame_done;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic       w_accept;
    logic       w_hit_max;
    logic       w_wr_en;
    logic       w_wr_last;
    logic       w_trunc;
    logic       w_pop;
    logic [8:0] w_rd_data;
    logic       w_frame_inc;
    logic       w_frame_dec;

    // NOTE: s_ready is the one unregistered output; it depends only on the
    // FIFO count, never on s_valid, so no combinational path runs in to out.
    assign s_ready     = (r_fifo_cnt != CW'(FIFO_DEPTH));
    assign w_accept    = s_valid && s_ready;

    // Byte number MAX_LEN of a frame is the last one that may be stored.
    assign w_hit_max   = (r_byte_cnt == LW'(MAX_LEN - 1));
    assign w_wr_en     = w_accept && !r_discard;
    assign w_wr_last   = s_last || w_hit_max;
    assign w_trunc     = w_wr_en && !s_last && w_hit_max;

    // The head entry is read directly, so a pop and its data line up in the same cycle.
    assign w_rd_data   = r_mem[r_rd_ptr];
    assign w_pop       = (r_state == ST_SFD) || ((r_state == ST_DATA) && !r_cur_last);

    assign w_frame_inc = w_wr_en && w_wr_last;
    assign w_frame_dec = w_pop && w_rd_data[8];

    assign txd           = r_txd;
    assign tx_en         = r_tx_en;
    assign tx_frame_done = r_tx_frame_done;
    assign trunc_err     = r_trunc_err;

    // ------------------------------------------------------------------
    // Payload storage: write accepted bytes with their (possibly forced) last flag
    // ------------------------------------------------------------------
    // NOTE: the array itself has no reset; clearing the pointers and counts
    // empties the FIFO. Stale entries are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {w_wr_last, s_data};
        end
    end

    // ------------------------------------------------------------------
    // Incoming frame tracking: byte count, truncation and tail discard
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every block sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte_cnt  <= '0;
            r_discard   <= 1'b0;
            r_trunc_err <= 1'b0;
        end else begin
            r_trunc_err <= w_trunc;
            if (w_accept) begin
                if (r_discard) begin
                    // Drop bytes until the real end of the oversized frame.
                    if (s_last) begin
                        r_discard <= 1'b0;
                    end
                end else if (s_last) begin
                    r_byte_cnt <= '0;
                end else if (w_hit_max) begin
                    r_byte_cnt <= '0;
                    r_discard  <= 1'b1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + LW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and complete-frame count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_wr_en, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            case ({w_frame_inc, w_frame_dec})
                2'b10:   r_frame_cnt <= r_frame_cnt + CW'(1);
                2'b01:   r_frame_cnt <= r_frame_cnt - CW'(1);
                default: r_frame_cnt <= r_frame_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM: the state names what txd/tx_en carry in this cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_tcnt          <= '0;
            r_fcs           <= '0;
            r_cur_last      <= 1'b0;
            r_txd           <= '0;
            r_tx_en         <= 1'b0;
            r_tx_frame_done <= 1'b0;
        end else begin
            r_tx_frame_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_txd   <= '0;
                    r_tx_en <= 1'b0;
                    if (r_frame_cnt != '0) begin
                        // The first preamble byte goes out from this edge.
                        r_state <= ST_PRE;
                        r_txd   <= PRE_BYTE;
                        r_tx_en <= 1'b1;
                        r_tcnt  <= TCW'(1);
                    end
                end

                ST_PRE: begin
                    // r_tcnt counts preamble bytes already on the line.
                    if (r_tcnt == TCW'(PRE_LEN)) begin
                        r_state <= ST_SFD;
                        r_txd   <= SFD_BYTE;
                    end else begin
                        r_tcnt <= r_tcnt + TCW'(1);
                    end
                end

                ST_SFD: begin
                    // The accumulator restarts from the first payload byte.
                    r_state    <= ST_DATA;
                    r_txd      <= w_rd_data[7:0];
                    r_fcs      <= w_rd_data[7:0];
                    r_cur_last <= w_rd_data[8];
                end

                ST_DATA: begin
                    if (r_cur_last) begin
                        r_state         <= ST_FCS;
                        r_txd           <= r_fcs;
                        r_tx_frame_done <= 1'b1;
                    end else begin
                        r_txd      <= w_rd_data[7:0];
                        r_fcs      <= r_fcs ^ w_rd_data[7:0];
                        r_cur_last <= w_rd_data[8];
                    end
                end

                ST_FCS: begin
                    r_state    <= ST_IFG;
                    r_txd      <= '0;
                    r_tx_en    <= 1'b0;
                    r_cur_last <= 1'b0;
                    r_tcnt     <= TCW'(1);
                end

                ST_IFG: begin
                    // r_tcnt counts idle cycles already on the line.
                    if (r_tcnt == TCW'(IFG_LEN)) begin
                        if (r_frame_cnt != '0) begin
                            r_state <= ST_PRE;
                            r_txd   <= PRE_BYTE;
                            r_tx_en <= 1'b1;
                            r_tcnt  <= TCW'(1);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + TCW'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= '0;
                    r_tx_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: directed, table-driven bench for frame_tx.
// A table of frames with hand-computed FCS and truncation points drives the
// main loop; hand-written sequences cover back-to-back gaps, FIFO-full
// backpressure, upstream stalls and reset in the middle of a frame.
module tb_frame_tx;

    localparam int PRE_LEN    = 7;
    localparam int IFG_LEN    = 12;
    localparam int MAX_LEN    = 64;
    localparam int FIFO_DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] txd;
    logic       tx_en;
    logic       tx_frame_done;
    logic       trunc_err;

    frame_tx #(
        .PRE_LEN   (PRE_LEN),
        .IFG_LEN   (IFG_LEN),
        .MAX_LEN   (MAX_LEN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .txd          (txd),
        .tx_en        (tx_en),
        .tx_frame_done(tx_frame_done),
        .trunc_err    (trunc_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Line monitor: collects every frame seen on txd/tx_en
    // ------------------------------------------------------------------
    bit         mon_on = 0;
    bit         prev_en = 0;
    int         cur_len = 0;
    int         cur_start = 0;
    int         cur_done = -1;
    int         idle_cnt = 1000;
    logic [7:0] rx_bytes[$];
    int         rx_len[$];
    int         rx_start[$];
    int         rx_done[$];
    int         rx_gap[$];
    int         txd_idle_bad = 0;
    int         done_bad = 0;
    int         trunc_cnt = 0;
    bit         saw_full = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (tx_en === 1'b1) begin
                if (!prev_en) begin
                    cur_len   = 0;
                    cur_done  = -1;
                    cur_start = cyc;
                    rx_gap.push_back(idle_cnt);
                end
                rx_bytes.push_back(txd);
                cur_len++;
                if (tx_frame_done === 1'b1) cur_done = cur_len;
            end else begin
                if (txd !== 8'h00) txd_idle_bad++;
                if (tx_frame_done !== 1'b0) done_bad++;
                if (prev_en) begin
                    rx_len.push_back(cur_len);
                    rx_start.push_back(cur_start);
                    rx_done.push_back(cur_done);
                    idle_cnt = 0;
                end
                idle_cnt++;
            end
            prev_en = (tx_en === 1'b1);
            if (trunc_err === 1'b1) trunc_cnt++;
            if (s_ready === 1'b0) saw_full = 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus and frame-checking helpers
    // ------------------------------------------------------------------
    task automatic push_byte(input logic [7:0] d, input logic last,
                             output logic trunc_seen, output int acc_cyc);
        int waited = 0;
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        while (s_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (s_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, waited);
        end
        @(posedge clk);
        #1;
        trunc_seen = trunc_err;
        acc_cyc    = cyc;
    endtask

    task automatic idle_input();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    int         fr_len, fr_start, fr_done, fr_gap;
    logic [7:0] fr_bytes[$];
    logic [7:0] exp_pl[$];

    task automatic get_frame(output bit ok);
        int w = 0;
        while (rx_len.size() == 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        if (rx_len.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: no frame seen within %0d cycles, expected one", w);
            ok = 0;
            return;
        end
        ok       = 1;
        fr_len   = rx_len.pop_front();
        fr_start = rx_start.pop_front();
        fr_done  = rx_done.pop_front();
        fr_gap   = rx_gap.pop_front();
        fr_bytes.delete();
        for (int i = 0; i < fr_len; i++) fr_bytes.push_back(rx_bytes.pop_front());
    endtask

    // Compares the next received frame with exp_pl and the expected FCS.
    task automatic check_frame(input string name, input logic [7:0] exp_fcs);
        bit ok;
        int bad_pre = 0;
        int bad_pl  = 0;
        int exp_len;
        get_frame(ok);
        if (!ok) return;
        exp_len = PRE_LEN + exp_pl.size() + 2;
        check($sformatf("%s tx_en_len", name), fr_len, exp_len);
        if (fr_len == exp_len) begin
            for (int i = 0; i < PRE_LEN; i++) if (fr_bytes[i] !== 8'h55) bad_pre++;
            for (int i = 0; i < exp_pl.size(); i++)
                if (fr_bytes[PRE_LEN + 1 + i] !== exp_pl[i]) bad_pl++;
            check($sformatf("%s preamble_errs", name), bad_pre, 0);
            check($sformatf("%s sfd", name), fr_bytes[PRE_LEN], 8'hD5);
            check($sformatf("%s payload_errs", name), bad_pl, 0);
            check($sformatf("%s fcs", name), fr_bytes[fr_len - 1], exp_fcs);
        end
        check($sformatf("%s done_pos", name), fr_done, exp_len);
    endtask

    // ------------------------------------------------------------------
    // Frame table: payload byte i = base + i*step
    // ------------------------------------------------------------------
    typedef struct {
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        int         exp_sent;
        logic [7:0] exp_fcs;
        int         exp_trunc;  // payload index that raises trunc_err, -1 if none
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic tr;
        int   acc;
        int   last_acc;
        int   first_tr;
        int   trunc0;
        int   en_bad;
        int   w;
        logic [7:0] fcs;

        vecs[0] = '{4,  8'h11, 8'h11, 4,  8'h44, -1};  // 11 22 33 44
        vecs[1] = '{1,  8'hA5, 8'h00, 1,  8'hA5, -1};
        vecs[2] = '{2,  8'h0F, 8'hF0, 2,  8'hF0, -1};  // 0F FF
        vecs[3] = '{3,  8'h01, 8'h02, 3,  8'h07, -1};  // 01 03 05
        vecs[4] = '{64, 8'h00, 8'h01, 64, 8'h00, -1};  // exactly MAX_LEN
        vecs[5] = '{70, 8'h00, 8'h01, 64, 8'h00, 63};  // truncated, 6 bytes dropped
        vecs[6] = '{65, 8'h00, 8'h01, 64, 8'h00, 63};  // dropped tail is the s_last byte
        vecs[7] = '{1,  8'h3C, 8'h00, 1,  8'h3C, -1};  // clean after discard
        vecs[8] = '{63, 8'h80, 8'h01, 63, 8'hBF, -1};  // XOR(80..BE) = BF

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset txd", txd, 8'h00);
        check("reset tx_en", tx_en, 1'b0);
        check("reset tx_frame_done", tx_frame_done, 1'b0);
        check("reset trunc_err", trunc_err, 1'b0);
        check("reset s_ready", s_ready, 1'b1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1;

        // Table-driven frames, one at a time from an idle transmitter
        for (int v = 0; v < 9; v++) begin
            trunc0   = trunc_cnt;
            first_tr = -1;
            last_acc = 0;
            for (int i = 0; i < vecs[v].len; i++) begin
                push_byte(8'(vecs[v].base + i * vecs[v].step), (i == vecs[v].len - 1), tr, acc);
                if (tr === 1'b1 && first_tr < 0) first_tr = i;
                last_acc = acc;
            end
            idle_input();
            exp_pl.delete();
            for (int i = 0; i < vecs[v].exp_sent; i++) exp_pl.push_back(8'(vecs[v].base + i * vecs[v].step));
            check_frame($sformatf("vec%0d", v), vecs[v].exp_fcs);
            check($sformatf("vec%0d trunc_idx", v), first_tr, vecs[v].exp_trunc);
            check($sformatf("vec%0d trunc_pulses", v), trunc_cnt - trunc0, (vecs[v].exp_trunc >= 0) ? 1 : 0);
            if (vecs[v].exp_trunc < 0)
                check($sformatf("vec%0d start_latency", v), fr_start - last_acc, 1);
            repeat (IFG_LEN + 4) @(posedge clk);
        end

        // Back-to-back 1-byte frames: second preamble exactly IFG_LEN after first FCS
        push_byte(8'hA5, 1'b1, tr, acc);
        push_byte(8'h3C, 1'b1, tr, acc);
        idle_input();
        exp_pl.delete(); exp_pl.push_back(8'hA5);
        check_frame("b2b first", 8'hA5);
        exp_pl.delete(); exp_pl.push_back(8'h3C);
        check_frame("b2b second", 8'h3C);
        check("b2b gap", fr_gap, IFG_LEN);
        repeat (IFG_LEN + 4) @(posedge clk);

        // Continuous 64-byte frames with s_valid held high
        saw_full = 0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 64; i++)
                push_byte(8'(i * 3 + f * 5), (i == 63), tr, acc);
        idle_input();
        for (int f = 0; f < 3; f++) begin
            exp_pl.delete();
            fcs = 8'h00;
            for (int i = 0; i < 64; i++) begin
                exp_pl.push_back(8'(i * 3 + f * 5));
                fcs = fcs ^ 8'(i * 3 + f * 5);
            end
            check_frame($sformatf("stream%0d", f), fcs);
            if (f > 0) check($sformatf("stream%0d gap_ok", f), (fr_gap >= IFG_LEN), 1'b1);
        end
        check("stream s_ready_dropped", saw_full, 1'b1);
        repeat (IFG_LEN + 4) @(posedge clk);

        // Upstream stall mid-frame: nothing is sent until s_last is accepted
        for (int i = 0; i < 3; i++) push_byte(8'(8'h10 * (i + 1)), 1'b0, tr, acc);
        idle_input();
        en_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_en !== 1'b0) en_bad++;
        end
        check("stall tx_en_during_gap", en_bad, 0);
        push_byte(8'h40, 1'b0, tr, acc);
        push_byte(8'h50, 1'b1, tr, acc);
        idle_input();
        exp_pl.delete();
        for (int i = 0; i < 5; i++) exp_pl.push_back(8'(8'h10 * (i + 1)));
        check_frame("stall", 8'h10);
        repeat (IFG_LEN + 4) @(posedge clk);

        // Reset during DATA of a 10-byte frame
        for (int i = 0; i < 10; i++) push_byte(8'(8'h20 + i), (i == 9), tr, acc);
        idle_input();
        w = 0;
        while (!(tx_en === 1'b1 && cur_len >= PRE_LEN + 4) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("rst reached_data", (tx_en === 1'b1 && cur_len >= PRE_LEN + 4), 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst tx_en", tx_en, 1'b0);
        check("rst txd", txd, 8'h00);
        check("rst s_ready", s_ready, 1'b1);
        check("rst tx_frame_done", tx_frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_bytes.delete(); rx_len.delete(); rx_start.delete(); rx_done.delete(); rx_gap.delete();
        repeat (IFG_LEN + 4) @(posedge clk);
        check("rst no_leftover_frame", rx_len.size(), 0);
        push_byte(8'h5A, 1'b1, tr, acc);
        idle_input();
        exp_pl.delete(); exp_pl.push_back(8'h5A);
        check_frame("post_rst", 8'h5A);
        check("post_rst start_latency", fr_start - acc, 1);
        repeat (IFG_LEN + 4) @(posedge clk);

        // Line-level invariants over the whole run
        check("txd_zero_when_idle violations", txd_idle_bad, 0);
        check("done_outside_frame violations", done_bad, 0);
        check("spurious_frames", rx_len.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
